// File: rtl/jtoutrun_obj_buffer.sv
// Double-buffered sprite line buffer: priority-merging write side,
// read-then-clear pixel side, and a post-reset clear sweep of both banks.
module jtoutrun_obj_buffer #(
   parameter logic [13:0] CLRVAL = 14'h3FFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pxl_cen,
   input  logic        hstart,
   input  logic [8:0]  bf_addr,
   input  logic [13:0] bf_data,
   input  logic        bf_we,
   input  logic [8:0]  hdump,
   output logic [13:0] obj_pxl,
   output logic        init_busy
);

   typedef enum logic { CLEAR, RUN } state_t;

   state_t      st;
   logic [8:0]  cnt;
   logic        line;
   logic        eff_line;
   logic        run;

   logic        s0_valid;
   logic [8:0]  s0_addr;
   logic [13:0] s0_data;
   logic        s0_bank;

   logic        s1_valid;
   logic [8:0]  s1_addr;
   logic [13:0] s1_data;
   logic        s1_bank;

   logic        rd_valid;
   logic [8:0]  rd_addr;
   logic        rd_bank;

   logic [13:0] mem0 [0:511];
   logic [13:0] mem1 [0:511];
   logic [13:0] rq0, rq1;
   logic [8:0]  raddr0, raddr1;

   logic        we0, we1;
   logic [8:0]  wa0, wa1;
   logic [13:0] wd0, wd1;

   logic [13:0] stored;
   logic [13:0] merged;

   // A same-clk hstart already counts for both the write and read sides
   assign eff_line = line ^ hstart;
   assign run      = (st == RUN);

   always_comb begin
      raddr0 = eff_line ? hdump   : bf_addr;
      raddr1 = eff_line ? bf_addr : hdump;
   end

   always_comb begin
      stored = s0_bank ? rq1 : rq0;
      if (s1_valid && s1_bank == s0_bank && s1_addr == s0_addr)
         stored = s1_data;
      if (stored[3:0] == 4'hF || s0_data[5:4] >= stored[5:4])
         merged = s0_data;
      else
         merged = stored;
   end

   // Pipeline write-back outranks a read clear on the same bank
   always_comb begin
      we0 = 1'b0;
      wa0 = 9'd0;
      wd0 = CLRVAL;
      if (!run) begin
         we0 = 1'b1;
         wa0 = cnt;
      end else if (s0_valid && !s0_bank) begin
         we0 = 1'b1;
         wa0 = s0_addr;
         wd0 = merged;
      end else if (rd_valid && !rd_bank) begin
         we0 = 1'b1;
         wa0 = rd_addr;
      end
   end

   always_comb begin
      we1 = 1'b0;
      wa1 = 9'd0;
      wd1 = CLRVAL;
      if (!run) begin
         we1 = 1'b1;
         wa1 = cnt;
      end else if (s0_valid && s0_bank) begin
         we1 = 1'b1;
         wa1 = s0_addr;
         wd1 = merged;
      end else if (rd_valid && rd_bank) begin
         we1 = 1'b1;
         wa1 = rd_addr;
      end
   end

   always_ff @(posedge clk) begin
      rq0 <= mem0[raddr0];
      if (we0) mem0[wa0] <= wd0;
   end

   always_ff @(posedge clk) begin
      rq1 <= mem1[raddr1];
      if (we1) mem1[wa1] <= wd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= CLEAR;
         cnt       <= 9'd0;
         init_busy <= 1'b1;
      end else begin
         unique case (st)
            CLEAR: begin
               cnt <= cnt + 9'd1;
               if (cnt == 9'd511) begin
                  st        <= RUN;
                  init_busy <= 1'b0;
               end
            end
            RUN: begin
               init_busy <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line     <= 1'b0;
         s0_valid <= 1'b0;
         s0_addr  <= 9'd0;
         s0_data  <= CLRVAL;
         s0_bank  <= 1'b0;
         s1_valid <= 1'b0;
         s1_addr  <= 9'd0;
         s1_data  <= CLRVAL;
         s1_bank  <= 1'b0;
         rd_valid <= 1'b0;
         rd_addr  <= 9'd0;
         rd_bank  <= 1'b0;
         obj_pxl  <= CLRVAL;
      end else begin
         line <= eff_line;

         s0_valid <= bf_we && run;
         if (bf_we) begin
            s0_addr <= bf_addr;
            s0_data <= bf_data;
            s0_bank <= eff_line;
         end

         s1_valid <= s0_valid;
         s1_addr  <= s0_addr;
         s1_data  <= merged;
         s1_bank  <= s0_bank;

         rd_valid <= pxl_cen && run;
         if (pxl_cen) begin
            rd_addr <= hdump;
            rd_bank <= ~eff_line;
         end

         if (!run)
            obj_pxl <= CLRVAL;
         else if (rd_valid)
            obj_pxl <= rd_bank ? rq1 : rq0;
      end
   end

endmodule

// File: tb/tb_jtoutrun_obj_buffer.sv
// Directed bench for jtoutrun_obj_buffer: init sweep, merge, bypass,
// bank swap timing and mid-line reset.
module tb_jtoutrun_obj_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pxl_cen = 1'b0;
   logic        hstart = 1'b0;
   logic [8:0]  bf_addr = 9'd0;
   logic [13:0] bf_data = 14'd0;
   logic        bf_we = 1'b0;
   logic [8:0]  hdump = 9'd0;
   logic [13:0] obj_pxl;
   logic        init_busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   jtoutrun_obj_buffer #(.CLRVAL(14'h3FFF)) dut (
      .clk       (clk),
      .rst       (rst),
      .pxl_cen   (pxl_cen),
      .hstart    (hstart),
      .bf_addr   (bf_addr),
      .bf_data   (bf_data),
      .bf_we     (bf_we),
      .hdump     (hdump),
      .obj_pxl   (obj_pxl),
      .init_busy (init_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [8:0] a, input logic [13:0] d);
      bf_addr = a;
      bf_data = d;
      bf_we   = 1'b1;
      step();
      bf_we   = 1'b0;
   endtask

   task automatic wr2(input logic [8:0] a, input logic [13:0] d1,
                      input logic [13:0] d2);
      bf_addr = a;
      bf_data = d1;
      bf_we   = 1'b1;
      step();
      bf_data = d2;
      step();
      bf_we   = 1'b0;
   endtask

   task automatic swap();
      step();
      step();
      hstart = 1'b1;
      step();
      hstart = 1'b0;
   endtask

   task automatic rd(input logic [8:0] a, output logic [13:0] v);
      hdump   = a;
      pxl_cen = 1'b1;
      step();
      pxl_cen = 1'b0;
      step();
      v = obj_pxl;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (init_busy && n < 600) begin
         step();
         n++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [13:0] v;
      int n;

      #12;
      chk("rst_obj_pxl", 32'(obj_pxl), 32'h3FFF);
      chk("rst_busy", 32'(init_busy), 32'd1);

      bf_addr = 9'h005;
      bf_data = 14'h0000;
      bf_we   = 1'b1;
      rst     = 1'b0;
      wait_init(n);
      bf_we   = 1'b0;
      chk("init_len", 32'(n), 32'd512);
      chk("init_obj_pxl", 32'(obj_pxl), 32'h3FFF);

      swap();
      rd(9'h005, v);
      chk("clr_rd_005", 32'(v), 32'h3FFF);
      rd(9'h1FF, v);
      chk("clr_rd_1ff", 32'(v), 32'h3FFF);

      wr(9'h010, 14'h0125);
      swap();
      rd(9'h010, v);
      chk("rd_010", 32'(v), 32'h0125);
      step();
      step();
      chk("hold_010", 32'(obj_pxl), 32'h0125);
      swap();
      swap();
      rd(9'h010, v);
      chk("rd_010_cleared", 32'(v), 32'h3FFF);

      wr2(9'h020, 14'h0021, 14'h0011);
      wr2(9'h021, 14'h0011, 14'h0021);
      swap();
      rd(9'h020, v);
      chk("byp_hi_lo", 32'(v), 32'h0021);
      rd(9'h021, v);
      chk("byp_lo_hi", 32'(v), 32'h0021);

      wr2(9'h030, 14'h0031, 14'h003F);
      wr(9'h031, 14'h0031);
      step();
      wr(9'h031, 14'h002F);
      wr(9'h032, 14'h0025);
      step();
      wr(9'h032, 14'h0016);
      wr(9'h033, 14'h0012);
      step();
      wr(9'h033, 14'h0015);
      swap();
      rd(9'h030, v);
      chk("eq_prio_transp", 32'(v), 32'h003F);
      rd(9'h031, v);
      chk("lo_prio_transp", 32'(v), 32'h0031);
      rd(9'h032, v);
      chk("lo_prio_keep", 32'(v), 32'h0025);
      rd(9'h033, v);
      chk("eq_prio_over", 32'(v), 32'h0015);

      bf_addr = 9'h050;
      bf_data = 14'h0123;
      bf_we   = 1'b1;
      step();
      bf_we   = 1'b0;
      hstart  = 1'b1;
      step();
      hstart  = 1'b0;
      rd(9'h050, v);
      chk("late_swap_050", 32'(v), 32'h0123);

      bf_addr = 9'h060;
      bf_data = 14'h0044;
      bf_we   = 1'b1;
      hstart  = 1'b1;
      step();
      bf_we   = 1'b0;
      hstart  = 1'b0;
      swap();
      rd(9'h060, v);
      chk("same_clk_swap_060", 32'(v), 32'h0044);

      bf_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bf_addr = 9'(9'h070 + i);
         bf_data = 14'h0011;
         step();
      end
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_obj_pxl", 32'(obj_pxl), 32'h3FFF);
      chk("midrst_busy", 32'(init_busy), 32'd1);
      rst = 1'b0;
      wait_init(n);
      bf_we = 1'b0;
      chk("reinit_len", 32'(n), 32'd512);
      swap();
      rd(9'h073, v);
      chk("reinit_rd_073", 32'(v), 32'h3FFF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
